echo_delay_ctrl: RTL

- Sequences a single-port 16-bit delay-line RAM for the echo effect: one read of the delayed sample, then one write of the new sample, per incoming audio sample.
- Mixes the delayed sample into the live sample with saturation and presents the result downstream with a one-cycle ready strobe.
- Sits between the sample source (sample_in/sample_in_ready) and the audio output path; the RAM itself is external to this block.

---
 rtl/echo_delay_ctrl.sv | 81 ++++++++
 1 files changed

// File: rtl/echo_delay_ctrl.sv
// echo_delay_ctrl: sequences a single-port delay-line RAM and mixes the attenuated echo into each live sample
module echo_delay_ctrl #(
  parameter int ADDR_WIDTH  = 15,
  parameter int ATTEN_SHIFT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  song_done,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] delay_len,
  input  logic                  sample_in_ready,
  input  logic [15:0]           sample_in,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [15:0]           ram_wdata,
  input  logic [15:0]           ram_rdata,
  output logic [15:0]           sample_out,
  output logic                  sample_out_ready,
  output logic                  busy,
  output logic                  overrun
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, MIX, WRITE} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] wr_ptr, fill_cnt, dly_reg;
  logic [15:0] in_reg, out_reg, hold_q;
  logic en_reg, accept, hist_ok;
  logic signed [15:0] d, sat;
  logic signed [16:0] mix;
  assign accept = sample_in_ready && state == IDLE && !song_done;
  always_comb begin
    state_nx = state;
    if (song_done) state_nx = IDLE;
    else if (state == IDLE) state_nx = sample_in_ready ? READ : IDLE;
    else state_nx = state == WRITE ? IDLE : state_t'(state + 3'd1);
  end
  // echo term only counts once the requested delay has really been recorded
  always_comb begin
    hist_ok = dly_reg != '0 && fill_cnt >= dly_reg;
    d = hist_ok ? $signed(ram_rdata) >>> ATTEN_SHIFT : 16'sd0;
    mix = $signed({in_reg[15], in_reg}) + $signed({d[15], d});
    sat = mix[16] != mix[15] ? (mix[16] ? 16'sh8000 : 16'sh7fff) : mix[15:0];
  end
  // read address is held from READ through MIX so any RAM latency is covered
  assign ram_addr = state == WRITE ? wr_ptr : wr_ptr - dly_reg;
  assign ram_we = state == WRITE && !song_done;
  assign ram_wdata = in_reg;
  assign sample_out_ready = ram_we;
  assign sample_out = sample_out_ready ? out_reg : hold_q;
  assign busy = state != IDLE;
  assign overrun = sample_in_ready && busy && !song_done;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      fill_cnt <= '0;
      dly_reg <= '0;
      in_reg <= '0;
      out_reg <= '0;
      hold_q <= '0;
      en_reg <= 1'b0;
    end else begin
      state <= state_nx;
      if (song_done) begin
        wr_ptr <= '0;
        fill_cnt <= '0;
      end else begin
        if (accept) begin
          in_reg <= sample_in;
          dly_reg <= delay_len;
          en_reg <= enable;
        end
        if (state == MIX) out_reg <= en_reg ? sat : in_reg;
        if (state == WRITE) begin
          hold_q <= out_reg;
          wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
          fill_cnt <= &fill_cnt ? fill_cnt : fill_cnt + ADDR_WIDTH'(1);
        end
      end
    end
  end
endmodule
